// File: rtl/regfile_arbiter_pkg.sv
// rtl/regfile_arbiter_pkg.sv - shared types and defaults for the register-file arbiter
// Purpose: FSM state enum, default widths and burst limit used by the
//          interface, the arbitration core and the top.
// Ports:   none (package).
package regfile_arbiter_pkg;

  localparam int DATA_W_DFLT    = 32;
  localparam int ADDR_W_DFLT    = 4;
  localparam int MAX_BURST_DFLT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_t;

endpackage

// File: rtl/regfile_arbiter_if.sv
// rtl/regfile_arbiter_if.sv - requester, register-file and scoreboard signal bundle
// Purpose: groups both requester ports, the register-file port and the
//          written scoreboard of regfile_arbiter.
// Modports:
//   slave  - arbiter side: takes requests and rf_data_out, drives grants,
//            read responses, rf_* controls and written.
//   master - environment side: the opposite directions.
interface regfile_arbiter_if
  import regfile_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int ADDR_W = ADDR_W_DFLT
);

  logic              req_a, we_a, lock_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] wdata_a;
  logic              gnt_a, rvalid_a, rerr_a;
  logic [DATA_W-1:0] rdata_a;

  logic              req_b, we_b, lock_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_b;
  logic              gnt_b, rvalid_b, rerr_b;
  logic [DATA_W-1:0] rdata_b;

  logic                   rf_write_en;
  logic [ADDR_W-1:0]      rf_write_line;
  logic [DATA_W-1:0]      rf_data_in;
  logic                   rf_read_en;
  logic [ADDR_W-1:0]      rf_read_line;
  logic [DATA_W-1:0]      rf_data_out;
  logic [2**ADDR_W-1:0]   written;

  modport slave (
    input  req_a, we_a, lock_a, addr_a, wdata_a,
    input  req_b, we_b, lock_b, addr_b, wdata_b,
    input  rf_data_out,
    output gnt_a, rvalid_a, rerr_a, rdata_a,
    output gnt_b, rvalid_b, rerr_b, rdata_b,
    output rf_write_en, rf_write_line, rf_data_in,
    output rf_read_en, rf_read_line, written
  );

  modport master (
    output req_a, we_a, lock_a, addr_a, wdata_a,
    output req_b, we_b, lock_b, addr_b, wdata_b,
    output rf_data_out,
    input  gnt_a, rvalid_a, rerr_a, rdata_a,
    input  gnt_b, rvalid_b, rerr_b, rdata_b,
    input  rf_write_en, rf_write_line, rf_data_in,
    input  rf_read_en, rf_read_line, written
  );

endinterface

// File: rtl/regfile_arbiter_rr_lock_arb.sv
// rtl/regfile_arbiter_rr_lock_arb.sv - two-way round-robin arbiter with bounded lock
// Purpose: combinational grant decision for two requesters.
// Ports:
//   i_req_a/i_req_b  - requests
//   i_state          - current ownership state
//   i_ptr_b          - last-granted pointer (1 = B was granted last)
//   i_burst_cnt      - consecutive locked grants of the current owner
//   o_gnt_a/o_gnt_b  - one-hot (or zero) grant
module rr_lock_arb
  import regfile_arbiter_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DFLT,
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic             i_req_a,
  input  logic             i_req_b,
  input  arb_state_t       i_state,
  input  logic             i_ptr_b,
  input  logic [CNT_W-1:0] i_burst_cnt,
  output logic             o_gnt_a,
  output logic             o_gnt_b
);

  logic w_sat;
  logic w_keep_a;
  logic w_keep_b;

  always_comb begin
    w_sat    = (i_burst_cnt == CNT_W'(MAX_BURST));
    // The owner keeps the bus unless it has used its full burst and the
    // other side is waiting.
    w_keep_a = (i_state == OWN_A) && i_req_a && !(w_sat && i_req_b);
    w_keep_b = (i_state == OWN_B) && i_req_b && !(w_sat && i_req_a);
    o_gnt_a  = 1'b0;
    o_gnt_b  = 1'b0;
    if (w_keep_a) begin
      o_gnt_a = 1'b1;
    end else if (w_keep_b) begin
      o_gnt_b = 1'b1;
    end else if (i_req_a && i_req_b) begin
      // An owner always is the last-granted side, so a released owner
      // loses the tie without extra pointer handling.
      o_gnt_a = i_ptr_b;
      o_gnt_b = !i_ptr_b;
    end else begin
      o_gnt_a = i_req_a;
      o_gnt_b = i_req_b;
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - two-requester register-file access arbiter
// Purpose: grants one register-file read or write per cycle to requester A
//          or B, returns registered read data with an unwritten-line error
//          flag, and keeps a per-line written scoreboard.
// Ports:
//   clk     - rising-edge clock
//   reset_n - synchronous active-low reset
//   bus     - regfile_arbiter_if.slave: requester A/B handshakes, rf_* port,
//             written scoreboard
module regfile_arbiter
  import regfile_arbiter_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DFLT,
  parameter int ADDR_W    = ADDR_W_DFLT,
  parameter int MAX_BURST = MAX_BURST_DFLT
) (
  input logic                clk,
  input logic                reset_n,
  regfile_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t         r_state;
  logic               r_ptr_b;
  logic [CNT_W-1:0]   r_cnt;

  logic               r_rvalid_a, r_rvalid_b;
  logic               r_rerr_a, r_rerr_b;
  logic [DATA_W-1:0]  r_rdata_a, r_rdata_b;
  logic [2**ADDR_W-1:0] r_written;

  logic               w_arb_gnt_a, w_arb_gnt_b;
  logic               w_gnt_a, w_gnt_b;
  logic               w_rd_a, w_rd_b, w_wr_a, w_wr_b;
  logic [CNT_W-1:0]   w_cnt_inc;

  rr_lock_arb #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_arb (
    .i_req_a     (bus.req_a),
    .i_req_b     (bus.req_b),
    .i_state     (r_state),
    .i_ptr_b     (r_ptr_b),
    .i_burst_cnt (r_cnt),
    .o_gnt_a     (w_arb_gnt_a),
    .o_gnt_b     (w_arb_gnt_b)
  );

  // Grants are suppressed while reset is held so nothing reaches the file.
  assign w_gnt_a   = reset_n & w_arb_gnt_a;
  assign w_gnt_b   = reset_n & w_arb_gnt_b;
  assign w_wr_a    = w_gnt_a &  bus.we_a;
  assign w_rd_a    = w_gnt_a & ~bus.we_a;
  assign w_wr_b    = w_gnt_b &  bus.we_b;
  assign w_rd_b    = w_gnt_b & ~bus.we_b;
  assign w_cnt_inc = (r_cnt == CNT_W'(MAX_BURST)) ? r_cnt : r_cnt + 1'b1;

  assign bus.gnt_a         = w_gnt_a;
  assign bus.gnt_b         = w_gnt_b;
  assign bus.rf_write_en   = w_wr_a | w_wr_b;
  assign bus.rf_write_line = w_wr_a ? bus.addr_a  : (w_wr_b ? bus.addr_b  : '0);
  assign bus.rf_data_in    = w_wr_a ? bus.wdata_a : (w_wr_b ? bus.wdata_b : '0);
  assign bus.rf_read_en    = w_rd_a | w_rd_b;
  assign bus.rf_read_line  = w_rd_a ? bus.addr_a  : (w_rd_b ? bus.addr_b  : '0);

  // rvalid is masked during reset so a read granted just before reset
  // never shows a response.
  assign bus.rvalid_a = r_rvalid_a & reset_n;
  assign bus.rvalid_b = r_rvalid_b & reset_n;
  assign bus.rerr_a   = r_rerr_a;
  assign bus.rerr_b   = r_rerr_b;
  assign bus.rdata_a  = r_rdata_a;
  assign bus.rdata_b  = r_rdata_b;
  assign bus.written  = r_written;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_ptr_b <= 1'b1;
      r_cnt   <= '0;
    end else if (w_gnt_a) begin
      r_ptr_b <= 1'b0;
      if (bus.lock_a) begin
        r_state <= OWN_A;
        r_cnt   <= (r_state == OWN_A) ? w_cnt_inc : CNT_W'(1);
      end else begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end
    end else if (w_gnt_b) begin
      r_ptr_b <= 1'b1;
      if (bus.lock_b) begin
        r_state <= OWN_B;
        r_cnt   <= (r_state == OWN_B) ? w_cnt_inc : CNT_W'(1);
      end else begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end
    end else begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rvalid_a <= 1'b0;
      r_rvalid_b <= 1'b0;
      r_rerr_a   <= 1'b0;
      r_rerr_b   <= 1'b0;
      r_rdata_a  <= '0;
      r_rdata_b  <= '0;
      r_written  <= '0;
    end else begin
      r_rvalid_a <= w_rd_a;
      r_rvalid_b <= w_rd_b;
      if (w_rd_a) begin
        r_rdata_a <= bus.rf_data_out;
        r_rerr_a  <= ~r_written[bus.addr_a];
      end
      if (w_rd_b) begin
        r_rdata_b <= bus.rf_data_out;
        r_rerr_b  <= ~r_written[bus.addr_b];
      end
      if (bus.rf_write_en) begin
        r_written[bus.rf_write_line] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - self-checking bench for regfile_arbiter
module tb_regfile_arbiter;
  import regfile_arbiter_pkg::*;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NL = 16;
  localparam int MB = MAX_BURST_DFLT;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  regfile_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_BURST(MB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Register-file stand-in: combinational read, write on the clock edge.
  logic [DW-1:0] rf_mem [NL] = '{default: '0};
  assign bus.rf_data_out = rf_mem[bus.rf_read_line];
  always @(posedge clk) if (bus.rf_write_en) rf_mem[bus.rf_write_line] <= bus.rf_data_in;

  // Stimulus per requester (0 = A, 1 = B).
  bit            req  [2];
  bit            we   [2];
  bit            lock [2];
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdata[2];

  // Reference model.
  int            m_owner;      // -1 nobody, 0 A, 1 B
  int            m_cnt;
  int            m_last;
  int            m_win;
  bit [NL-1:0]   m_written;
  logic [DW-1:0] m_mem [NL] = '{default: '0};
  bit            e_rvalid [2];
  bit            e_rerr   [2];
  logic [DW-1:0] e_rdata  [2];
  bit            obs_g    [2];

  int n_checks;
  int n_fail;
  int exp4 [7] = '{0, 0, 0, 0, 1, 0, 0};
  int a_left;
  bit b_pend;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int x, input bit r, input bit w, input bit l,
                         input int a, input logic [DW-1:0] d);
    req[x] = r; we[x] = w; lock[x] = l; addr[x] = AW'(a); wdata[x] = d;
  endtask

  task automatic clear_reqs();
    set_req(0, 0, 0, 0, 0, '0);
    set_req(1, 0, 0, 0, 0, '0);
  endtask

  // One clock: drive at negedge, check at negedge+1, advance the model,
  // return #1 after the posedge.
  task automatic cycle(input bit rst_n);
    int win;
    bit wr;
    bit rd;
    logic [AW-1:0] eline;
    logic [DW-1:0] edata;
    @(negedge clk);
    reset_n = rst_n;
    bus.req_a = req[0]; bus.we_a = we[0]; bus.lock_a = lock[0];
    bus.addr_a = addr[0]; bus.wdata_a = wdata[0];
    bus.req_b = req[1]; bus.we_b = we[1]; bus.lock_b = lock[1];
    bus.addr_b = addr[1]; bus.wdata_b = wdata[1];
    #1;
    win = -1;
    if (rst_n) begin
      if (m_owner >= 0 && req[m_owner] && !(m_cnt == MB && req[1 - m_owner])) win = m_owner;
      else if (req[0] && req[1]) win = 1 - m_last;
      else if (req[0]) win = 0;
      else if (req[1]) win = 1;
    end
    wr = 0; rd = 0; eline = '0; edata = '0;
    if (win >= 0) begin
      wr = we[win];
      rd = !we[win];
      eline = addr[win];
      edata = wdata[win];
    end
    check("gnt_a", 64'(bus.gnt_a), 64'(win == 0));
    check("gnt_b", 64'(bus.gnt_b), 64'(win == 1));
    check("rf_write_en", 64'(bus.rf_write_en), 64'(wr));
    check("rf_read_en", 64'(bus.rf_read_en), 64'(rd));
    check("rf_write_line", 64'(bus.rf_write_line), wr ? 64'(eline) : 64'd0);
    check("rf_data_in", 64'(bus.rf_data_in), wr ? 64'(edata) : 64'd0);
    check("rf_read_line", 64'(bus.rf_read_line), rd ? 64'(eline) : 64'd0);
    check("rvalid_a", 64'(bus.rvalid_a), 64'(e_rvalid[0] && rst_n));
    check("rvalid_b", 64'(bus.rvalid_b), 64'(e_rvalid[1] && rst_n));
    check("rdata_a", 64'(bus.rdata_a), 64'(e_rdata[0]));
    check("rdata_b", 64'(bus.rdata_b), 64'(e_rdata[1]));
    if (e_rvalid[0]) check("rerr_a", 64'(bus.rerr_a), 64'(e_rerr[0]));
    if (e_rvalid[1]) check("rerr_b", 64'(bus.rerr_b), 64'(e_rerr[1]));
    check("written", 64'(bus.written), 64'(m_written));
    obs_g[0] = bus.gnt_a;
    obs_g[1] = bus.gnt_b;
    m_win = win;
    if (!rst_n) begin
      m_owner = -1; m_cnt = 0; m_last = 1; m_written = '0;
      for (int x = 0; x < 2; x++) begin
        e_rvalid[x] = 0; e_rerr[x] = 0; e_rdata[x] = '0;
      end
    end else begin
      e_rvalid[0] = 0;
      e_rvalid[1] = 0;
      if (win >= 0) begin
        if (we[win]) begin
          m_mem[addr[win]] = wdata[win];
          m_written[addr[win]] = 1'b1;
        end else begin
          e_rvalid[win] = 1;
          e_rdata[win]  = m_mem[addr[win]];
          e_rerr[win]   = !m_written[addr[win]];
        end
        if (lock[win]) begin
          m_cnt   = (m_owner == win) ? ((m_cnt < MB) ? m_cnt + 1 : MB) : 1;
          m_owner = win;
        end else begin
          m_owner = -1;
          m_cnt   = 0;
        end
        m_last = win;
      end else begin
        m_owner = -1;
        m_cnt   = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_owner = -1; m_cnt = 0; m_last = 1; m_win = -1; m_written = '0;
    for (int x = 0; x < 2; x++) begin
      e_rvalid[x] = 0; e_rerr[x] = 0; e_rdata[x] = '0;
    end
    clear_reqs();

    // Reset state.
    cycle(0);
    cycle(0);
    check("rst_written", 64'(bus.written), 64'd0);
    check("rst_rdata_a", 64'(bus.rdata_a), 64'd0);

    // A writes line 3, B reads it back the next cycle.
    set_req(0, 1, 1, 0, 3, 32'hDEADBEEF);
    cycle(1);
    check("s1_gnt_a", 64'(obs_g[0]), 64'd1);
    clear_reqs();
    set_req(1, 1, 0, 0, 3, '0);
    cycle(1);
    check("s1_gnt_b", 64'(obs_g[1]), 64'd1);
    check("s1_rvalid_b", 64'(bus.rvalid_b), 64'd1);
    check("s1_rdata_b", 64'(bus.rdata_b), 64'hDEADBEEF);
    check("s1_rerr_b", 64'(bus.rerr_b), 64'd0);
    check("s1_written3", 64'(bus.written[3]), 64'd1);
    clear_reqs();
    cycle(1);
    check("s1_rvalid_drop", 64'(bus.rvalid_b), 64'd0);
    check("s1_rdata_hold", 64'(bus.rdata_b), 64'hDEADBEEF);

    // B reads never-written line 7.
    set_req(1, 1, 0, 0, 7, '0);
    cycle(1);
    check("s2_rvalid_b", 64'(bus.rvalid_b), 64'd1);
    check("s2_rdata_b", 64'(bus.rdata_b), 64'd0);
    check("s2_rerr_b", 64'(bus.rerr_b), 64'd1);
    clear_reqs();

    // Both requesting without lock alternate A,B,A,B.
    cycle(0);
    set_req(0, 1, 0, 0, 3, '0);
    set_req(1, 1, 0, 0, 5, '0);
    for (int i = 0; i < 6; i++) begin
      cycle(1);
      check("s3_alt_a", 64'(obs_g[0]), 64'((i % 2) == 0));
      check("s3_alt_b", 64'(obs_g[1]), 64'((i % 2) == 1));
    end
    clear_reqs();

    // A locked for 6 transfers with B waiting: A x4, B x1, A resumes.
    cycle(0);
    a_left = 6;
    b_pend = 1;
    for (int i = 0; i < 7; i++) begin
      set_req(0, a_left > 0, 1, 1, a_left, 32'h1000 + 32'(a_left));
      set_req(1, b_pend, 0, 0, 2, '0);
      cycle(1);
      check("s4_gnt_a", 64'(obs_g[0]), 64'(exp4[i] == 0));
      check("s4_gnt_b", 64'(obs_g[1]), 64'(exp4[i] == 1));
      if (exp4[i] == 0) a_left--;
      else b_pend = 0;
    end
    clear_reqs();

    // A locked with B idle: granted every cycle past saturation.
    cycle(0);
    for (int i = 0; i < 6; i++) begin
      set_req(0, 1, 0, 1, i, '0);
      cycle(1);
      check("s5_gnt_a", 64'(obs_g[0]), 64'd1);
    end
    clear_reqs();

    // Read granted, then reset: no rvalid, scoreboard cleared, back to IDLE.
    set_req(0, 1, 1, 0, 9, 32'h55AA55AA);
    cycle(1);
    set_req(0, 1, 0, 0, 9, '0);
    cycle(1);
    check("s6_rvalid_pre", 64'(bus.rvalid_a), 64'd1);
    cycle(0);
    check("s6_gnt_in_rst", 64'(obs_g[0]), 64'd0);
    check("s6_rvalid_a", 64'(bus.rvalid_a), 64'd0);
    check("s6_written", 64'(bus.written), 64'd0);
    set_req(0, 1, 0, 0, 1, '0);
    set_req(1, 1, 0, 0, 1, '0);
    cycle(1);
    check("s6_idle_tie_a", 64'(obs_g[0]), 64'd1);
    clear_reqs();

    // Randomized traffic against the model; requests hold until granted.
    for (int i = 0; i < 400; i++) begin
      bit rst_n;
      for (int x = 0; x < 2; x++) begin
        if (!req[x] && $urandom_range(0, 2) != 0)
          set_req(x, 1, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                  int'($urandom_range(0, NL - 1)), $urandom);
      end
      rst_n = ($urandom_range(0, 49) != 0);
      cycle(rst_n);
      if (!rst_n) clear_reqs();
      else if (m_win >= 0) req[m_win] = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
